// File: rtl/digit_serial_adder.sv
// digit_serial_adder
//   Multi-cycle two's-complement adder/subtractor. A WIDTH-bit operand pair
//   is accepted over a valid/ready handshake, then added DIGIT bits per clock
//   through one DIGIT-bit ripple slice whose carry is held in a register
//   between digits. The result (sum, carry-out, signed overflow) is offered
//   over a second valid/ready handshake and held until taken.
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_valid   operand pair and mode present
//   in_ready   block can accept (IDLE only)
//   a, b       operands, WIDTH bits
//   cin        carry-in, add mode only
//   sub        1: a - b, 0: a + b + cin
//   out_valid  result held on sum/cout/ovf
//   out_ready  consumer takes the result
//   sum        WIDTH-bit result
//   cout       carry out of the MSB (subtract: 1 = no borrow)
//   ovf        signed overflow
module digit_serial_adder #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CW-1:0] LAST_DIGIT = CW'(NDIG - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic             carry_reg;
    logic [CW-1:0]    cnt_reg;
    logic [WIDTH-1:0] sum_reg;
    logic [WIDTH-1:0] sum_next;
    logic             cout_reg;
    logic             ovf_reg;

    // Ripple slice: chain[i] is the carry into bit i of the current digit,
    // so chain[DIGIT-1] is the carry into the operand MSB on the last digit.
    logic [DIGIT:0]   chain;
    logic [DIGIT-1:0] digit_sum;
    logic [WIDTH-1:0] a_shift;
    logic [WIDTH-1:0] b_shift;

    assign chain[0] = carry_reg;

    genvar gi;
    generate
        for (gi = 0; gi < DIGIT; gi++) begin : g_slice
            assign digit_sum[gi] = a_reg[gi] ^ b_reg[gi] ^ chain[gi];
            assign chain[gi+1]   = (a_reg[gi] & b_reg[gi]) |
                                   (chain[gi] & (a_reg[gi] ^ b_reg[gi]));
        end

        // With a single digit there is nothing left to shift in.
        if (DIGIT == WIDTH) begin : g_no_shift
            assign a_shift = '0;
            assign b_shift = '0;
        end else begin : g_shift
            assign a_shift = {{DIGIT{1'b0}}, a_reg[WIDTH-1:DIGIT]};
            assign b_shift = {{DIGIT{1'b0}}, b_reg[WIDTH-1:DIGIT]};
        end
    endgenerate

    // Place the current digit result at the slot selected by the counter.
    always_comb begin
        sum_next = sum_reg;
        for (int i = 0; i < NDIG; i++) begin
            if (cnt_reg == CW'(i)) begin
                sum_next[i*DIGIT +: DIGIT] = digit_sum;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            carry_reg <= 1'b0;
            cnt_reg   <= '0;
            sum_reg   <= '0;
            cout_reg  <= 1'b0;
            ovf_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        // Subtraction is a + ~b + 1: invert B, force carry-in.
                        a_reg     <= a;
                        b_reg     <= sub ? ~b : b;
                        carry_reg <= sub ? 1'b1 : cin;
                        cnt_reg   <= '0;
                        state_reg <= RUN;
                    end
                end
                RUN: begin
                    sum_reg   <= sum_next;
                    a_reg     <= a_shift;
                    b_reg     <= b_shift;
                    carry_reg <= chain[DIGIT];
                    if (cnt_reg == LAST_DIGIT) begin
                        cout_reg  <= chain[DIGIT];
                        ovf_reg   <= chain[DIGIT] ^ chain[DIGIT-1];
                        cnt_reg   <= '0;
                        state_reg <= DONE;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Handshake flags come straight from the state register.
    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == DONE);
    assign sum       = sum_reg;
    assign cout      = cout_reg;
    assign ovf       = ovf_reg;

endmodule

// File: tb/tb_digit_serial_adder.sv
// tb_digit_serial_adder
//   Self-checking bench for digit_serial_adder. Main instance WIDTH=16,
//   DIGIT=4; two corner instances (16/16 and 8/1). Expected results come
//   from an integer-arithmetic reference model or fixed constants.
module tb_digit_serial_adder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    // Main instance (WIDTH=16, DIGIT=4)
    logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0;
    logic [15:0] a = '0, b = '0, sum;
    logic        cin = 1'b0, sub = 1'b0, cout, ovf;

    // Corner instance WIDTH=16, DIGIT=16
    logic        w_in_valid = 1'b0, w_in_ready, w_out_valid, w_out_ready = 1'b0;
    logic [15:0] w_a = '0, w_b = '0, w_sum;
    logic        w_cin = 1'b0, w_sub = 1'b0, w_cout, w_ovf;

    // Corner instance WIDTH=8, DIGIT=1
    logic        n_in_valid = 1'b0, n_in_ready, n_out_valid, n_out_ready = 1'b0;
    logic [7:0]  n_a = '0, n_b = '0, n_sum;
    logic        n_cin = 1'b0, n_sub = 1'b0, n_cout, n_ovf;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    digit_serial_adder #(.WIDTH(16), .DIGIT(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
        .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf)
    );

    digit_serial_adder #(.WIDTH(16), .DIGIT(16)) u_wide (
        .clk(clk), .rst_n(rst_n), .in_valid(w_in_valid), .in_ready(w_in_ready),
        .a(w_a), .b(w_b), .cin(w_cin), .sub(w_sub), .out_valid(w_out_valid),
        .out_ready(w_out_ready), .sum(w_sum), .cout(w_cout), .ovf(w_ovf)
    );

    digit_serial_adder #(.WIDTH(8), .DIGIT(1)) u_narrow (
        .clk(clk), .rst_n(rst_n), .in_valid(n_in_valid), .in_ready(n_in_ready),
        .a(n_a), .b(n_b), .cin(n_cin), .sub(n_sub), .out_valid(n_out_valid),
        .out_ready(n_out_ready), .sum(n_sum), .cout(n_cout), .ovf(n_ovf)
    );

    // Reference: returns {ovf, cout, sum[15:0]} for a w-bit operation,
    // computed with plain unsigned and signed integer arithmetic.
    function automatic logic [17:0] model(input int w, input logic [15:0] ta,
                                          input logic [15:0] tb,
                                          input logic tcin, input logic tsub);
        longint m    = longint'(1) << w;
        longint ua   = longint'(ta) & (m - 1);
        longint ub   = longint'(tb) & (m - 1);
        longint c    = (!tsub && tcin) ? 1 : 0;
        longint tot  = tsub ? (ua + ((m - 1) - ub) + 1) : (ua + ub + c);
        longint sa   = (ua >= m / 2) ? ua - m : ua;
        longint sb   = (ub >= m / 2) ? ub - m : ub;
        longint sres = tsub ? (sa - sb) : (sa + sb + c);
        logic   co   = (tot >= m);
        logic   ov   = (sres < -(m / 2)) || (sres >= m / 2);
        return {ov, co, 16'(tot & (m - 1))};
    endfunction

    // Present one operation to the main instance and wait for its result.
    // Operand inputs are scrambled after the accept edge. lat = edges from
    // accept until out_valid is seen (100 means timeout).
    task automatic run_op(input logic [15:0] ta, input logic [15:0] tb,
                          input logic tcin, input logic tsub, output int lat);
        a = ta; b = tb; cin = tcin; sub = tsub; in_valid = 1'b1;
        for (int k = 0; k < 50 && !in_ready; k++) begin
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = 16'($urandom); b = 16'($urandom);
        cin = 1'($urandom); sub = 1'($urandom);
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        $display("txn a=%h b=%h cin=%0d sub=%0d -> sum=%h cout=%0d ovf=%0d lat=%0d",
                 ta, tb, tcin, tsub, sum, cout, ovf, lat);
    endtask

    task automatic finish_op();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
        end
        n_checks++;
        if (sum !== 16'h0000 || cout !== 1'b0 || ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs sum=%h cout=%b ovf=%b want 0000/0/0", sum, cout, ovf);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        logic [15:0] va[5] = '{16'hFFFF, 16'h7FFF, 16'h8000, 16'h0005, 16'h8000};
        logic [15:0] vb[5] = '{16'h0001, 16'h0000, 16'h8000, 16'h0007, 16'h0001};
        logic        vc[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic        vs[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [15:0] es[5] = '{16'h0000, 16'h8000, 16'h0000, 16'hFFFE, 16'h7FFF};
        logic        ec[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic        eo[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        int lat;
        for (int i = 0; i < 5; i++) begin
            run_op(va[i], vb[i], vc[i], vs[i], lat);
            n_checks++;
            if (sum !== es[i] || cout !== ec[i] || ovf !== eo[i]) begin
                n_fail++;
                $display("FAIL directed[%0d] got %h/%b/%b want %h/%b/%b",
                         i, sum, cout, ovf, es[i], ec[i], eo[i]);
            end
            n_checks++;
            if (lat != 4) begin
                n_fail++;
                $display("FAIL directed_latency[%0d] got %0d want 4", i, lat);
            end
            finish_op();
        end
    endtask

    task automatic test_random();
        logic [15:0] ta, tb;
        logic        tc, ts;
        logic [17:0] exp;
        int lat;
        for (int i = 0; i < 30; i++) begin
            ta = 16'($urandom); tb = 16'($urandom);
            tc = 1'($urandom);  ts = 1'($urandom);
            exp = model(16, ta, tb, tc, ts);
            run_op(ta, tb, tc, ts, lat);
            n_checks++;
            if ({ovf, cout, sum} !== exp || lat != 4) begin
                n_fail++;
                $display("FAIL random[%0d] got %h/%b/%b lat %0d want %h/%b/%b lat 4",
                         i, sum, cout, ovf, lat, exp[15:0], exp[16], exp[17]);
            end
            finish_op();
        end
    endtask

    task automatic test_backpressure();
        logic [17:0] exp;
        int lat;
        exp = model(16, 16'h1234, 16'h0FF0, 1'b0, 1'b1);
        run_op(16'h1234, 16'h0FF0, 1'b0, 1'b1, lat);
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if ({ovf, cout, sum} !== exp || in_ready !== 1'b0 || out_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL hold[%0d] got %h/%b/%b rdy=%b vld=%b want %h/%b/%b rdy=0 vld=1",
                         i, sum, cout, ovf, in_ready, out_valid, exp[15:0], exp[16], exp[17]);
            end
            @(posedge clk); #1;
        end
        finish_op();
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL release got vld=%b rdy=%b want 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_back_to_back();
        int times[$];
        out_ready = 1'b1;
        a = 16'h1111; b = 16'h2222; cin = 1'b0; sub = 1'b0;
        in_valid = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (out_valid) begin
                times.push_back(c);
                $display("txn b2b cycle=%0d sum=%h", c, sum);
                n_checks++;
                if (sum !== 16'h3333) begin
                    n_fail++;
                    $display("FAIL b2b_sum got %h want 3333", sum);
                end
            end
        end
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        out_ready = 1'b0;
        n_checks++;
        if (times.size() < 3) begin
            n_fail++;
            $display("FAIL b2b_count got %0d results want >= 3", times.size());
        end
        for (int i = 1; i < times.size(); i++) begin
            n_checks++;
            if (times[i] - times[i-1] != 6) begin
                n_fail++;
                $display("FAIL b2b_spacing[%0d] got %0d want 6", i, times[i] - times[i-1]);
            end
        end
    endtask

    task automatic test_reset_mid_run();
        int lat;
        int seen = 0;
        a = 16'hAAAA; b = 16'h5555; cin = 1'b1; sub = 1'b0; in_valid = 1'b1;
        for (int k = 0; k < 50 && !in_ready; k++) begin
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || sum !== 16'h0000) begin
            n_fail++;
            $display("FAIL mid_reset got rdy=%b vld=%b sum=%h want 1/0/0000",
                     in_ready, out_valid, sum);
        end
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        n_checks++;
        if (seen != 0) begin
            n_fail++;
            $display("FAIL mid_reset_no_output got %0d valid cycles want 0", seen);
        end
        run_op(16'h1234, 16'h1111, 1'b0, 1'b0, lat);
        n_checks++;
        if (sum !== 16'h2345 || lat != 4) begin
            n_fail++;
            $display("FAIL after_reset got %h lat %0d want 2345 lat 4", sum, lat);
        end
        finish_op();
    endtask

    task automatic test_param_corners();
        logic [15:0] ta, tb;
        logic        tc, ts;
        logic [17:0] exp;
        int lat;
        // WIDTH=16, DIGIT=16: one RUN cycle
        for (int i = 0; i < 6; i++) begin
            ta = (i == 0) ? 16'h1234 : 16'($urandom);
            tb = (i == 0) ? 16'h4321 : 16'($urandom);
            tc = (i == 0) ? 1'b0 : 1'($urandom);
            ts = (i == 0) ? 1'b0 : 1'($urandom);
            exp = model(16, ta, tb, tc, ts);
            w_a = ta; w_b = tb; w_cin = tc; w_sub = ts; w_in_valid = 1'b1;
            for (int k = 0; k < 50 && !w_in_ready; k++) begin
                @(posedge clk); #1;
            end
            @(posedge clk); #1;
            w_in_valid = 1'b0;
            w_a = 16'($urandom); w_b = 16'($urandom);
            lat = 0;
            while (!w_out_valid && lat < 100) begin
                @(posedge clk); #1;
                lat++;
            end
            $display("txn d16 a=%h b=%h cin=%0d sub=%0d -> sum=%h lat=%0d", ta, tb, tc, ts, w_sum, lat);
            n_checks++;
            if ({w_ovf, w_cout, w_sum} !== exp || lat != 1) begin
                n_fail++;
                $display("FAIL d16[%0d] got %h/%b/%b lat %0d want %h/%b/%b lat 1",
                         i, w_sum, w_cout, w_ovf, lat, exp[15:0], exp[16], exp[17]);
            end
            w_out_ready = 1'b1;
            @(posedge clk); #1;
            w_out_ready = 1'b0;
        end
        // WIDTH=8, DIGIT=1: eight RUN cycles
        for (int i = 0; i < 6; i++) begin
            ta = (i == 0) ? 16'h00FF : {8'h00, 8'($urandom)};
            tb = (i == 0) ? 16'h0001 : {8'h00, 8'($urandom)};
            tc = (i == 0) ? 1'b0 : 1'($urandom);
            ts = (i == 0) ? 1'b0 : 1'($urandom);
            exp = model(8, ta, tb, tc, ts);
            n_a = ta[7:0]; n_b = tb[7:0]; n_cin = tc; n_sub = ts; n_in_valid = 1'b1;
            for (int k = 0; k < 50 && !n_in_ready; k++) begin
                @(posedge clk); #1;
            end
            @(posedge clk); #1;
            n_in_valid = 1'b0;
            n_a = 8'($urandom); n_b = 8'($urandom);
            lat = 0;
            while (!n_out_valid && lat < 100) begin
                @(posedge clk); #1;
                lat++;
            end
            $display("txn d1 a=%h b=%h cin=%0d sub=%0d -> sum=%h lat=%0d", ta[7:0], tb[7:0], tc, ts, n_sum, lat);
            n_checks++;
            if ({n_ovf, n_cout, n_sum} !== {exp[17:16], exp[7:0]} || lat != 8) begin
                n_fail++;
                $display("FAIL d1[%0d] got %h/%b/%b lat %0d want %h/%b/%b lat 8",
                         i, n_sum, n_cout, n_ovf, lat, exp[7:0], exp[16], exp[17]);
            end
            n_out_ready = 1'b1;
            @(posedge clk); #1;
            n_out_ready = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_run();
        test_param_corners();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
